dispatch_queue: RTL and testbench

//  N_WAY-wide in-order FIFO between decode and the ROB/map-table dispatch group. Accepts up to
//  N_WAY decoded instructions per cycle and presents up to N_WAY oldest entries as dispatch_packet.

---
 rtl/dispatch_queue_pkg.sv | 28 ++
 rtl/dispatch_queue_if.sv | 26 ++
 rtl/dispatch_queue_chk.sv | 25 ++
 rtl/dispatch_queue_compact.sv | 29 ++
 rtl/dispatch_queue.sv | 166 ++++++++++++++++
 tb/tb_dispatch_queue.sv | 182 ++++++++++++++++++
 6 files changed

// File: rtl/dispatch_queue_pkg.sv
// Shared types and sizing for the dispatch queue: packet layout, FSM states, depth constants.
// N_WAY comes from the `N_WAY macro and falls back to 3 when it is not defined.
`ifndef N_WAY
`define N_WAY 3
`endif

package dispatch_queue_pkg;

    localparam int N_WAY    = `N_WAY;
    localparam int DQ_DEPTH = 8;
    localparam int CW       = $clog2(N_WAY) + 1;
    localparam int PW       = $clog2(DQ_DEPTH);
    localparam int QW       = PW + 1;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        halt;
        logic        illegal;
    } DISPATCH_PACKET;

    typedef enum logic [0:0] {
        DQ_RUN    = 1'b0,
        DQ_HALTED = 1'b1
    } DQ_STATE;

endpackage

// File: rtl/dispatch_queue_if.sv
// Decode-side and dispatch-side bundle of the dispatch queue.
// master = upstream/ROB side, slave = the queue.
interface dispatch_queue_if;
    import dispatch_queue_pkg::*;

    DISPATCH_PACKET [N_WAY-1:0] in_packet;
    logic [N_WAY-1:0]           in_branch;
    logic                       in_ready;
    DISPATCH_PACKET [N_WAY-1:0] dispatch_packet;
    logic [N_WAY-1:0]           branch_inst;
    logic [CW-1:0]              dispatch_num;
    logic [N_WAY-1:0]           dispatched;
    logic                       branch_haz;
    logic [QW-1:0]              count;

    modport master (
        output in_packet, in_branch, dispatched, branch_haz,
        input  in_ready, dispatch_packet, branch_inst, dispatch_num, count
    );

    modport slave (
        input  in_packet, in_branch, dispatched, branch_haz,
        output in_ready, dispatch_packet, branch_inst, dispatch_num, count
    );

endinterface

// File: rtl/dispatch_queue_chk.sv
// dq_checker: runtime checks for the dispatch queue (dispatched-mask shape, occupancy bound).
// mask_prefix_hits counts cycles whose dispatched mask had a bit set after its first zero.
module dq_checker
    import dispatch_queue_pkg::*;
(
    input logic             clock,
    input logic             reset,
    input logic [N_WAY-1:0] dispatched,
    input logic [N_WAY-1:0] pop_keep,
    input logic [QW-1:0]    count
);
    logic [15:0] mask_prefix_hits;

    // Sample both properties on every active clock edge out of reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mask_prefix_hits <= 16'd0;
        end else begin
            dq_mask_prefix: assert (dispatched == pop_keep)
                else mask_prefix_hits <= mask_prefix_hits + 16'd1;
            dq_no_overflow: assert (count <= QW'(DQ_DEPTH));
        end
    end

endmodule

// File: rtl/dispatch_queue_compact.sv
// dq_compact: lane compaction offsets plus popcount of a lane mask.
// PREFIX=1 keeps only the leading run of ones; pos[N] is the total kept.
module dq_compact #(
    parameter int N      = 3,
    parameter int W      = 3,
    parameter bit PREFIX = 1'b0
) (
    input  logic [N-1:0] mask,
    output logic [N-1:0] keep,
    output logic [W-1:0] pos [N+1]
);
    logic         run_s;
    logic [W-1:0] acc_s;

    // Kept lanes and the number of kept lanes below each lane
    always_comb begin
        run_s  = 1'b1;
        acc_s  = '0;
        keep   = '0;
        pos[0] = '0;
        for (int i = 0; i < N; i++) begin
            run_s      = run_s & mask[i];
            keep[i]    = PREFIX ? run_s : mask[i];
            acc_s      = acc_s + W'(keep[i]);
            pos[i + 1] = acc_s;
        end
    end

endmodule

// File: rtl/dispatch_queue.sv
// dispatch_queue: N_WAY-wide in-order FIFO between decode and dispatch, with halt FSM and flush.
// Define DQ_PERF_CNT_EN to add the stall_cycles / flush_count performance counters.
module dispatch_queue
    import dispatch_queue_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    dispatch_queue_if.slave dq
`ifdef DQ_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cycles,
    output logic [15:0]     flush_count
`endif
);
    localparam int DEPTH = DQ_DEPTH;

    DISPATCH_PACKET   mem_r [DEPTH];
    logic [DEPTH-1:0] br_r;
    logic [PW-1:0]    head_r;
    logic [PW-1:0]    tail_r;
    logic [QW-1:0]    count_r;
    DQ_STATE          state_r;
    DQ_STATE          state_next_s;
    logic             in_ready_s;
    logic             do_push_s;
    logic             stop_s;
    logic             halt_hit_s;
    logic [N_WAY-1:0] push_cand_s;
    logic [N_WAY-1:0] push_mask_s;
    logic [N_WAY-1:0] push_keep_s;
    logic [N_WAY-1:0] pop_keep_s;
    logic [CW-1:0]    push_pos_s [N_WAY+1];
    logic [CW-1:0]    pop_pos_s  [N_WAY+1];
    logic [CW-1:0]    k_s;
    logic [CW-1:0]    p_s;
    logic [PW-1:0]    rd_idx_s;

    // Intake: lanes after the first halting/illegal lane of a group are never pushed
    always_comb begin
        in_ready_s  = (state_r == DQ_RUN) && ((QW'(DEPTH) - count_r) >= QW'(N_WAY));
        do_push_s   = in_ready_s && !dq.branch_haz;
        stop_s      = 1'b0;
        push_cand_s = '0;
        for (int i = 0; i < N_WAY; i++) begin
            if (dq.in_packet[i].valid && !stop_s) begin
                push_cand_s[i] = 1'b1;
                stop_s         = dq.in_packet[i].halt || dq.in_packet[i].illegal;
            end else begin
                push_cand_s[i] = 1'b0;
            end
        end
        halt_hit_s  = do_push_s && stop_s;
        push_mask_s = do_push_s ? push_cand_s : '0;
    end

    dq_compact #(.N(N_WAY), .W(CW), .PREFIX(1'b0)) u_push (
        .mask (push_mask_s),
        .keep (push_keep_s),
        .pos  (push_pos_s)
    );

    dq_compact #(.N(N_WAY), .W(CW), .PREFIX(1'b1)) u_pop (
        .mask (dq.dispatched),
        .keep (pop_keep_s),
        .pos  (pop_pos_s)
    );

    dq_checker u_chk (
        .clock      (clock),
        .reset      (reset),
        .dispatched (dq.dispatched),
        .pop_keep   (pop_keep_s),
        .count      (count_r)
    );

    // Output window: the k oldest entries, remaining lanes forced to zero
    always_comb begin
        k_s                = (count_r >= QW'(N_WAY)) ? CW'(N_WAY) : CW'(count_r);
        p_s                = (pop_pos_s[N_WAY] > k_s) ? k_s : pop_pos_s[N_WAY];
        rd_idx_s           = head_r;
        dq.dispatch_packet = '0;
        dq.branch_inst     = '0;
        for (int j = 0; j < N_WAY; j++) begin
            rd_idx_s = head_r + PW'(j);
            if (CW'(j) < k_s) begin
                dq.dispatch_packet[j]       = mem_r[rd_idx_s];
                dq.dispatch_packet[j].valid = 1'b1;
                dq.branch_inst[j]           = br_r[rd_idx_s];
            end else begin
                dq.dispatch_packet[j] = '0;
                dq.branch_inst[j]     = 1'b0;
            end
        end
        dq.dispatch_num = k_s;
    end

    assign dq.in_ready = in_ready_s;
    assign dq.count    = count_r;

    // FSM next state: flush always returns to RUN, halt is sticky otherwise
    always_comb begin
        state_next_s = state_r;
        if (dq.branch_haz) begin
            state_next_s = DQ_RUN;
        end else begin
            case (state_r)
                DQ_RUN:    state_next_s = halt_hit_s ? DQ_HALTED : DQ_RUN;
                DQ_HALTED: state_next_s = DQ_HALTED;
                default:   state_next_s = DQ_RUN;
            endcase
        end
    end

    // Pointers, occupancy and FSM state; flush discards same-cycle push and pop
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            state_r <= DQ_RUN;
        end else if (dq.branch_haz) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            state_r <= state_next_s;
        end else begin
            head_r  <= head_r + PW'(p_s);
            tail_r  <= tail_r + PW'(push_pos_s[N_WAY]);
            count_r <= count_r + QW'(push_pos_s[N_WAY]) - QW'(p_s);
            state_r <= state_next_s;
        end
    end

    // Entry storage: kept lanes land at tail plus their compacted offset
    always_ff @(posedge clock) begin
        for (int i = 0; i < N_WAY; i++) begin
            if (push_keep_s[i]) begin
                mem_r[tail_r + PW'(push_pos_s[i])] <= dq.in_packet[i];
                br_r[tail_r + PW'(push_pos_s[i])]  <= dq.in_branch[i];
            end
        end
    end

`ifdef DQ_PERF_CNT_EN
    // Saturating stall and flush event counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cycles <= 32'd0;
            flush_count  <= 16'd0;
        end else begin
            if ((state_r == DQ_RUN) && !in_ready_s && (|dq.in_packet) &&
                (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end else begin
                stall_cycles <= stall_cycles;
            end
            if (dq.branch_haz && (flush_count != 16'hFFFF)) begin
                flush_count <= flush_count + 16'd1;
            end else begin
                flush_count <= flush_count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed self-checking bench for dispatch_queue (N_WAY=3, DEPTH=8).
module tb_dispatch_queue;
    import dispatch_queue_pkg::*;

    typedef DISPATCH_PACKET [N_WAY-1:0] grp_t;

    logic           clock = 1'b0;
    logic           reset;
    int             tests_run    = 0;
    int             tests_failed = 0;
    DISPATCH_PACKET nop = '0;
    logic [15:0]    hits_before;

    dispatch_queue_if dqi ();

`ifdef DQ_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    dispatch_queue u_dut (
        .clock (clock),
        .reset (reset),
        .dq    (dqi)
`ifdef DQ_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    always #5 clock = ~clock;

    function automatic DISPATCH_PACKET mk(input logic [31:0] pc, input logic halt);
        DISPATCH_PACKET p;
        p         = '0;
        p.valid   = 1'b1;
        p.pc      = pc;
        p.inst    = 32'h0000_0013;
        p.halt    = halt;
        return p;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        dqi.in_packet  = '0;
        dqi.in_branch  = '0;
        dqi.dispatched = '0;
        dqi.branch_haz = 1'b0;
    endtask

    task automatic cycle(input grp_t g, input logic [N_WAY-1:0] br,
                         input logic [N_WAY-1:0] disp, input logic haz);
        dqi.in_packet  = g;
        dqi.in_branch  = br;
        dqi.dispatched = disp;
        dqi.branch_haz = haz;
        @(posedge clock);
        #1;
        idle();
    endtask

    initial begin
        reset = 1'b0;
        idle();
        repeat (2) @(posedge clock);
        #1;
        check_val("rst_ready", 64'(dqi.in_ready), 64'd1);
        check_val("rst_num",   64'(dqi.dispatch_num), 64'd0);
        check_val("rst_count", 64'(dqi.count), 64'd0);
        check_val("rst_pkt",   64'(|dqi.dispatch_packet), 64'd0);
        check_val("rst_br",    64'(dqi.branch_inst), 64'd0);
        reset = 1'b1;

        // 1: three lanes in, oldest first out
        cycle(grp_t'({mk(32'h8, 1'b0), mk(32'h4, 1'b0), mk(32'h0, 1'b0)}), 3'b010, 3'b000, 1'b0);
        check_val("t1_num",   64'(dqi.dispatch_num), 64'd3);
        check_val("t1_pc0",   64'(dqi.dispatch_packet[0].pc), 64'h0);
        check_val("t1_pc1",   64'(dqi.dispatch_packet[1].pc), 64'h4);
        check_val("t1_pc2",   64'(dqi.dispatch_packet[2].pc), 64'h8);
        check_val("t1_valid", 64'({dqi.dispatch_packet[2].valid, dqi.dispatch_packet[1].valid,
                                   dqi.dispatch_packet[0].valid}), 64'd7);
        check_val("t1_br",    64'(dqi.branch_inst), 64'b010);
        check_val("t1_count", 64'(dqi.count), 64'd3);
        cycle(grp_t'('0), 3'b000, 3'b111, 1'b0);
        check_val("t1_pop_count", 64'(dqi.count), 64'd0);
        check_val("t1_pop_num",   64'(dqi.dispatch_num), 64'd0);

        // 2: sparse valid mask is compacted
        cycle(grp_t'({mk(32'h18, 1'b0), nop, mk(32'h10, 1'b0)}), 3'b100, 3'b000, 1'b0);
        check_val("t2_num",   64'(dqi.dispatch_num), 64'd2);
        check_val("t2_pc0",   64'(dqi.dispatch_packet[0].pc), 64'h10);
        check_val("t2_pc1",   64'(dqi.dispatch_packet[1].pc), 64'h18);
        check_val("t2_lane2", 64'(|dqi.dispatch_packet[2]), 64'd0);
        check_val("t2_br",    64'(dqi.branch_inst), 64'b010);
        check_val("t2_count", 64'(dqi.count), 64'd2);

        // 3: fill to 6, ready drops; pop 2 while a group is refused
        cycle(grp_t'({mk(32'h28, 1'b0), mk(32'h24, 1'b0), mk(32'h20, 1'b0)}), 3'b000, 3'b000, 1'b0);
        check_val("t3_ready5", 64'(dqi.in_ready), 64'd1);
        cycle(grp_t'({nop, nop, mk(32'h2c, 1'b0)}), 3'b000, 3'b000, 1'b0);
        check_val("t3_count6", 64'(dqi.count), 64'd6);
        check_val("t3_ready6", 64'(dqi.in_ready), 64'd0);
        cycle(grp_t'({mk(32'h38, 1'b0), mk(32'h34, 1'b0), mk(32'h30, 1'b0)}), 3'b000, 3'b011, 1'b0);
        check_val("t3_count", 64'(dqi.count), 64'd4);
        check_val("t3_ready", 64'(dqi.in_ready), 64'd1);
        check_val("t3_pc0",   64'(dqi.dispatch_packet[0].pc), 64'h20);
        check_val("t3_pc2",   64'(dqi.dispatch_packet[2].pc), 64'h28);

        // 4: non-prefix dispatched mask pops only the leading one
        cycle(grp_t'('0), 3'b000, 3'b001, 1'b0);
        check_val("t4_count3", 64'(dqi.count), 64'd3);
        hits_before = u_dut.u_chk.mask_prefix_hits;
        check_val("t4_hits0", 64'(hits_before), 64'd0);
        cycle(grp_t'('0), 3'b000, 3'b101, 1'b0);
        check_val("t4_count", 64'(dqi.count), 64'd2);
        check_val("t4_pc0",   64'(dqi.dispatch_packet[0].pc), 64'h28);
        check_val("t4_pc1",   64'(dqi.dispatch_packet[1].pc), 64'h2c);
        check_val("t4_hits",  64'(u_dut.u_chk.mask_prefix_hits), 64'd1);

        // 5: halt on lane1 drops lane2, queue drains, flush resumes
        cycle(grp_t'({mk(32'h48, 1'b0), mk(32'h44, 1'b1), mk(32'h40, 1'b0)}), 3'b000, 3'b000, 1'b0);
        check_val("t5_ready", 64'(dqi.in_ready), 64'd0);
        check_val("t5_count", 64'(dqi.count), 64'd4);
        check_val("t5_pc2",   64'(dqi.dispatch_packet[2].pc), 64'h40);
        cycle(grp_t'({mk(32'h58, 1'b0), mk(32'h54, 1'b0), mk(32'h50, 1'b0)}), 3'b000, 3'b111, 1'b0);
        check_val("t5_drain_count", 64'(dqi.count), 64'd1);
        check_val("t5_pc0",         64'(dqi.dispatch_packet[0].pc), 64'h44);
        check_val("t5_halt0",       64'(dqi.dispatch_packet[0].halt), 64'd1);
        check_val("t5_ready_h",     64'(dqi.in_ready), 64'd0);
        cycle(grp_t'('0), 3'b000, 3'b001, 1'b0);
        check_val("t5_empty_num",   64'(dqi.dispatch_num), 64'd0);
        check_val("t5_empty_ready", 64'(dqi.in_ready), 64'd0);
        cycle(grp_t'('0), 3'b000, 3'b000, 1'b1);
        check_val("t5_flush_ready", 64'(dqi.in_ready), 64'd1);
        check_val("t5_flush_count", 64'(dqi.count), 64'd0);

        // 6: pointer wrap within a group, then flush with simultaneous push and pop
        cycle(grp_t'({mk(32'h108, 1'b0), mk(32'h104, 1'b0), mk(32'h100, 1'b0)}), 3'b000, 3'b000, 1'b0);
        check_val("t6a_count", 64'(dqi.count), 64'd3);
        cycle(grp_t'({mk(32'h114, 1'b0), mk(32'h110, 1'b0), mk(32'h10c, 1'b0)}), 3'b000, 3'b111, 1'b0);
        check_val("t6b_count", 64'(dqi.count), 64'd3);
        check_val("t6b_pc0",   64'(dqi.dispatch_packet[0].pc), 64'h10c);
        cycle(grp_t'({mk(32'h120, 1'b0), mk(32'h11c, 1'b0), mk(32'h118, 1'b0)}), 3'b000, 3'b111, 1'b0);
        check_val("t6c_count", 64'(dqi.count), 64'd3);
        check_val("t6c_pc0",   64'(dqi.dispatch_packet[0].pc), 64'h118);
        check_val("t6c_pc1",   64'(dqi.dispatch_packet[1].pc), 64'h11c);
        check_val("t6c_pc2",   64'(dqi.dispatch_packet[2].pc), 64'h120);
        cycle(grp_t'({mk(32'h208, 1'b0), mk(32'h204, 1'b0), mk(32'h200, 1'b0)}), 3'b000, 3'b111, 1'b1);
        check_val("t6d_count", 64'(dqi.count), 64'd0);
        check_val("t6d_num",   64'(dqi.dispatch_num), 64'd0);
        check_val("t6d_ready", 64'(dqi.in_ready), 64'd1);
        check_val("t6d_pkt",   64'(|dqi.dispatch_packet), 64'd0);
        cycle(grp_t'({nop, nop, mk(32'h99, 1'b0)}), 3'b000, 3'b000, 1'b0);
        check_val("t6e_pc0", 64'(dqi.dispatch_packet[0].pc), 64'h99);
        check_val("t6e_num", 64'(dqi.dispatch_num), 64'd1);

        // Asynchronous reset mid-operation clears state without a clock edge
        #2;
        reset = 1'b0;
        #1;
        check_val("arst_count", 64'(dqi.count), 64'd0);
        check_val("arst_num",   64'(dqi.dispatch_num), 64'd0);
        check_val("arst_ready", 64'(dqi.in_ready), 64'd1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_val("arst_after_count", 64'(dqi.count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
